peripheral_system_irq_controller: RTL and testbench
===================================================

PERIPHERAL_SYSTEM_IRQ_CONTROLLER -- requirements
Module: peripheral_system_irq_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt inputs (legal 1..16).
REQ-002 SHALL have parameter RESET_MASK, default 0, mask register value after reset.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port address, input, 3, Avalon-MM slave word address.
REQ-006 SHALL have port chipselect, input, 1, slave select.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 16, write data.
REQ-009 SHALL have port readdata, output, 16, registered read data.
REQ-010 SHALL have port irq_in, input, NUM_IRQ, interrupt requests from timers and peripherals, clk-domain.
REQ-011 SHALL have port irq, output, 1, aggregated interrupt to the CPU.

Function
REQ-012 SHALL register irq_in into irq_q every cycle; all detection uses irq_q.
REQ-013 SHALL implement registers: 0 PENDING (read; write-1-to-clear), 1 MASK (R/W), 2 MODE (R/W; bit=1 edge, 0 level), 3 VECTOR (read-only), 4 RAW (read irq_q), 5 SOFTSET (write-1-to-set pending; reads 0); addresses 6-7 read 0, writes ignored.
REQ-014 SHALL, for an edge-mode bit, set pending on irq_q rising edge (irq_q=1, previous irq_q=0).
REQ-015 SHALL, for an edge-mode bit, give set priority over a same-cycle W1C clear.
REQ-016 SHALL, for a level-mode bit, hold pending equal to irq_q OR a latched soft bit; W1C clears only the soft bit.
REQ-017 SHALL apply a MODE change at the next cycle without clearing pending.
REQ-018 SHALL drive irq registered: irq = |(pending & MASK) from the previous cycle (one-cycle latency from pending update).
REQ-019 SHALL compute VECTOR as {valid at bit 15, zeros, index at bits 3:0}, index = lowest-numbered bit of pending & MASK; valid=0 and index=0 when none.
REQ-020 SHALL return readdata one cycle after the address is presented (read latency 1), independent of chipselect, as a registered mux.
REQ-021 SHALL ignore writedata bits at and above NUM_IRQ; such bits read 0.
REQ-022 SHALL make a write to PENDING/SOFTSET visible in readdata for a read issued the following cycle.
REQ-023 SHALL, when a source edge, SOFTSET write and W1C on the same bit coincide, leave the bit pending.

Reset
REQ-024 SHALL, while reset is high at a clk edge, clear irq_q, previous irq_q, pending, soft bits, MODE and readdata, set MASK to RESET_MASK, and drive irq=0.
REQ-025 SHALL abandon any in-progress access when reset asserts mid-operation; an edge present during reset SHALL NOT be latched afterwards unless irq_q re-rises.

Structure
REQ-026 SHALL place register address constants, register-width constants and the VECTOR field layout in the shared package peripheral_system_pkg.
REQ-027 SHALL implement the lowest-index search in one sub-module, peripheral_system_irq_prio_enc (input NUM_IRQ-bit vector; outputs valid, 4-bit index).

Verification
REQ-028 SHALL cover: MASK=0x0001, MODE=0x0001, pulse irq_in[0] one cycle -> PENDING=0x0001, irq=1 at two cycles after the pulse; write PENDING=0x0001 -> irq=0 two cycles later.
REQ-029 SHALL cover: MODE=0, MASK=0x0004, hold irq_in[2]=1 -> irq=1; W1C 0x0004 -> PENDING stays 0x0004; drop irq_in[2] -> PENDING=0, irq=0.
REQ-030 SHALL cover: MASK=0x00FF, pending bits 3 and 6 set -> VECTOR=0x8003; clear bit 3 -> VECTOR=0x8006; clear bit 6 -> VECTOR=0x0000.
REQ-031 SHALL cover: edge mode, irq_in[1] rising edge coincident with W1C 0x0002 -> PENDING bit 1 remains 1.
REQ-032 SHALL cover: SOFTSET 0x0010 with MASK=0 -> PENDING=0x0010, irq=0; MASK=0x0010 -> irq=1 one cycle after MASK updates.
REQ-033 SHALL cover: reset pulsed while pending=0x00FF, irq=1 -> cycle after reset: PENDING=0, MASK=RESET_MASK, irq=0, readdata=0.

Source files
------------

// File: rtl/peripheral_system_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_system_pkg
// Purpose : Shared constants for the peripheral-system interrupt controller.
//           It holds the register map, the register and index widths, and the
//           bit layout of the VECTOR register, with a helper that builds it.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package peripheral_system_pkg;

   localparam int REG_W   = 16;   // bus data / register width
   localparam int ADDR_W  = 3;    // word address width
   localparam int IDX_W   = 4;    // interrupt index width (up to 16 sources)
   localparam int MAX_IRQ = 16;

   // Register map (word addresses)
   typedef enum logic [ADDR_W-1:0] {
      REG_PENDING = 3'd0,   // read; write-1-to-clear
      REG_MASK    = 3'd1,   // read/write
      REG_MODE    = 3'd2,   // read/write; 1 = edge, 0 = level
      REG_VECTOR  = 3'd3,   // read-only
      REG_RAW     = 3'd4,   // read synchronised inputs
      REG_SOFTSET = 3'd5,   // write-1-to-set pending; reads 0
      REG_RSVD6   = 3'd6,
      REG_RSVD7   = 3'd7
   } reg_addr_e;

   // VECTOR layout: {valid, zeros, index}
   localparam int VEC_VALID_BIT = 15;
   localparam int VEC_IDX_MSB   = 3;
   localparam int VEC_IDX_LSB   = 0;

   function automatic logic [REG_W-1:0] pack_vector(input logic             valid,
                                                    input logic [IDX_W-1:0] idx);
      logic [REG_W-1:0] v;
      v = '0;
      v[VEC_VALID_BIT]           = valid;
      v[VEC_IDX_MSB:VEC_IDX_LSB] = idx;
      return v;
   endfunction

endpackage

// File: rtl/peripheral_system_irq_prio_enc.sv
// -----------------------------------------------------------------------------
// peripheral_system_irq_prio_enc
// Purpose : Lowest-index priority encoder over the active interrupt vector.
// Ports   : i_req   - NUM_IRQ request bits (pending & mask)
//           o_valid - at least one request bit is set
//           o_index - index of the lowest set bit, 0 when none set
// -----------------------------------------------------------------------------
module peripheral_system_irq_prio_enc
   import peripheral_system_pkg::*;
#(
   parameter int NUM_IRQ = 8
)(
   input  logic [NUM_IRQ-1:0] i_req,
   output logic               o_valid,
   output logic [IDX_W-1:0]   o_index
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      o_valid = 1'b0;
      o_index = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_valid = 1'b1;
            o_index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/peripheral_system_irq_controller.sv
// -----------------------------------------------------------------------------
// peripheral_system_irq_controller
// Purpose : Avalon-MM interrupt controller. It aggregates NUM_IRQ request lines,
//           which can be edge or level sensitive per bit, into one masked CPU
//           interrupt. It also provides a lowest-index VECTOR register.
// Ports   : clk        - sole clock, rising edge
//           reset      - synchronous active-high reset
//           address    - slave word address
//           chipselect - slave select
//           write_n    - active-low write strobe
//           writedata  - write data
//           readdata   - registered read data, latency 1
//           irq_in     - interrupt requests (clk domain)
//           irq        - registered aggregated interrupt
// -----------------------------------------------------------------------------
module peripheral_system_irq_controller
   import peripheral_system_pkg::*;
#(
   parameter int               NUM_IRQ    = 8,
   parameter logic [REG_W-1:0] RESET_MASK = '0
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [REG_W-1:0]   writedata,
   output logic [REG_W-1:0]   readdata,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq
);

   logic [NUM_IRQ-1:0] r_irq_q;
   logic [NUM_IRQ-1:0] r_irq_prev;
   logic               r_first;      // first clock after reset release
   logic [NUM_IRQ-1:0] r_latch;      // edge-captured and software-set bits
   logic [NUM_IRQ-1:0] r_mask;
   logic [NUM_IRQ-1:0] r_mode;
   logic [REG_W-1:0]   r_readdata;
   logic               r_irq;

   logic               w_wr;
   logic [NUM_IRQ-1:0] w_wdata;
   logic [NUM_IRQ-1:0] w_w1c;
   logic [NUM_IRQ-1:0] w_softset;
   logic [NUM_IRQ-1:0] w_rise;
   logic [NUM_IRQ-1:0] w_pending;
   logic [NUM_IRQ-1:0] w_latch_next;
   logic [NUM_IRQ-1:0] w_active;
   logic               w_vec_valid;
   logic [IDX_W-1:0]   w_vec_index;
   logic [REG_W-1:0]   w_vector;
   logic [REG_W-1:0]   w_rd_mux;

   // Bits above NUM_IRQ are intentionally dropped.
   generate
      if (NUM_IRQ < REG_W) begin : g_unused_hi
         logic w_unused_wdata;
         assign w_unused_wdata = ^writedata[REG_W-1:NUM_IRQ];
      end
   endgenerate

   assign w_wr      = chipselect & ~write_n;
   assign w_wdata   = writedata[NUM_IRQ-1:0];
   assign w_w1c     = (w_wr && address == REG_PENDING) ? w_wdata : '0;
   assign w_softset = (w_wr && address == REG_SOFTSET) ? w_wdata : '0;
   assign w_rise    = r_irq_q & ~r_irq_prev;

   // Level bits follow the synchronised input live. The latch only holds
   // edge captures and soft sets, so W1C on a level bit clears only its
   // soft part. Because sets are OR-ed in after the clear, a coincident
   // edge or soft set always wins over W1C.
   assign w_pending    = r_latch | (r_irq_q & ~r_mode);
   assign w_latch_next = (r_latch & ~w_w1c) | w_softset | (w_rise & r_mode);
   assign w_active     = w_pending & r_mask;

   peripheral_system_irq_prio_enc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio_enc (
      .i_req   (w_active),
      .o_valid (w_vec_valid),
      .o_index (w_vec_index)
   );

   assign w_vector = pack_vector(w_vec_valid, w_vec_index);

   always_comb begin
      w_rd_mux = '0;
      case (reg_addr_e'(address))
         REG_PENDING: w_rd_mux = REG_W'(w_pending);
         REG_MASK:    w_rd_mux = REG_W'(r_mask);
         REG_MODE:    w_rd_mux = REG_W'(r_mode);
         REG_VECTOR:  w_rd_mux = w_vector;
         REG_RAW:     w_rd_mux = REG_W'(r_irq_q);
         default:     w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_q    <= '0;
         r_irq_prev <= '0;
         r_first    <= 1'b1;
         r_latch    <= '0;
         r_mask     <= RESET_MASK[NUM_IRQ-1:0];
         r_mode     <= '0;
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_first <= 1'b0;
         r_irq_q <= irq_in;
         // On the first sample after reset, seed the history with the same
         // value. A line already high during reset is then not taken as an edge.
         r_irq_prev <= r_first ? irq_in : r_irq_q;
         r_latch    <= w_latch_next;
         if (w_wr && address == REG_MASK) begin
            r_mask <= w_wdata;
         end
         if (w_wr && address == REG_MODE) begin
            r_mode <= w_wdata;
         end
         r_readdata <= w_rd_mux;
         r_irq      <= |w_active;
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule

// File: tb/tb_peripheral_system_irq_controller.sv
module tb_peripheral_system_irq_controller;

   localparam int          NUM_IRQ  = 8;
   localparam logic [15:0] RST_MASK = 16'h0005;

   localparam logic [2:0] A_PEND = 3'd0;
   localparam logic [2:0] A_MASK = 3'd1;
   localparam logic [2:0] A_MODE = 3'd2;
   localparam logic [2:0] A_VEC  = 3'd3;
   localparam logic [2:0] A_RAW  = 3'd4;
   localparam logic [2:0] A_SOFT = 3'd5;
   localparam logic [2:0] A_R6   = 3'd6;
   localparam logic [2:0] A_R7   = 3'd7;

   logic               clk = 1'b0;
   logic               reset;
   logic [2:0]         address;
   logic               chipselect;
   logic               write_n;
   logic [15:0]        writedata;
   logic [15:0]        readdata;
   logic [NUM_IRQ-1:0] irq_in;
   logic               irq;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [15:0] exp;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      bit          is_wr;
      logic [2:0]  addr;
      logic [15:0] data;
      logic [7:0]  irqv;
      logic [15:0] exp;
      string       name;
   } vec_t;
   vec_t tbl[$];

   peripheral_system_irq_controller #(
      .NUM_IRQ    (NUM_IRQ),
      .RESET_MASK (RST_MASK)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq_in     (irq_in),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_irq(input string name, input logic exp);
      check(name, {15'b0, irq}, {15'b0, exp});
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      $display("wr  addr=%0d data=%h", a, d);
   endtask

   // Push the expectation when the read is issued; pop it when readdata appears.
   task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp);
      sb_t e;
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      sb_q.push_back('{name, exp});
      tick();
      chipselect = 1'b0;
      if (sb_q.size() == 0) begin
         check({name, "_sb_empty"}, 16'h0001, 16'h0000);
      end else begin
         e = sb_q.pop_front();
         $display("rd  addr=%0d data=%h (%s)", a, readdata, e.name);
         check(e.name, readdata, e.exp);
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      irq_in     = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = '0;
      writedata  = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      irq_in     = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = '0;
      writedata  = '0;

      // ---------------- register map table ----------------
      tbl.push_back('{1'b0, A_MASK, 16'h0000, 8'h00, 16'h0005, "rst_mask"});
      tbl.push_back('{1'b0, A_PEND, 16'h0000, 8'h00, 16'h0000, "rst_pend"});
      tbl.push_back('{1'b0, A_MODE, 16'h0000, 8'h00, 16'h0000, "rst_mode"});
      tbl.push_back('{1'b0, A_VEC,  16'h0000, 8'h00, 16'h0000, "rst_vec"});
      tbl.push_back('{1'b0, A_RAW,  16'h0000, 8'h00, 16'h0000, "rst_raw"});
      tbl.push_back('{1'b1, A_MASK, 16'hFFFF, 8'h00, 16'h0000, "w_mask"});
      tbl.push_back('{1'b0, A_MASK, 16'h0000, 8'h00, 16'h00FF, "mask_trunc"});
      tbl.push_back('{1'b1, A_MODE, 16'hA5C3, 8'h00, 16'h0000, "w_mode"});
      tbl.push_back('{1'b0, A_MODE, 16'h0000, 8'h00, 16'h00C3, "mode_rw"});
      tbl.push_back('{1'b1, A_R6,   16'hFFFF, 8'h00, 16'h0000, "w_r6"});
      tbl.push_back('{1'b0, A_R6,   16'h0000, 8'h00, 16'h0000, "addr6_zero"});
      tbl.push_back('{1'b0, A_R7,   16'h0000, 8'h00, 16'h0000, "addr7_zero"});
      tbl.push_back('{1'b0, A_MASK, 16'h0000, 8'h00, 16'h00FF, "mask_kept"});
      tbl.push_back('{1'b0, A_SOFT, 16'h0000, 8'h00, 16'h0000, "soft_reads0"});
      tbl.push_back('{1'b1, A_SOFT, 16'h0180, 8'h00, 16'h0000, "w_soft"});
      tbl.push_back('{1'b0, A_PEND, 16'h0000, 8'h00, 16'h0080, "soft_trunc"});
      tbl.push_back('{1'b0, A_VEC,  16'h0000, 8'h00, 16'h8007, "vec_b7"});
      tbl.push_back('{1'b1, A_PEND, 16'h0080, 8'h00, 16'h0000, "w_w1c"});
      tbl.push_back('{1'b0, A_PEND, 16'h0000, 8'h00, 16'h0000, "w1c_edge"});
      tbl.push_back('{1'b1, A_MODE, 16'h0000, 8'h00, 16'h0000, "w_mode0"});
      tbl.push_back('{1'b1, A_R7,   16'h0000, 8'h5A, 16'h0000, "settle"});
      tbl.push_back('{1'b0, A_RAW,  16'h0000, 8'h5A, 16'h005A, "raw"});
      tbl.push_back('{1'b0, A_PEND, 16'h0000, 8'h5A, 16'h005A, "level_pend"});
      tbl.push_back('{1'b0, A_VEC,  16'h0000, 8'h5A, 16'h8001, "vec_level"});
      tbl.push_back('{1'b1, A_R6,   16'h0000, 8'h00, 16'h0000, "drop"});

      tick();
      tick();
      // Reset state right after a reset edge
      check("rst_readdata", readdata, 16'h0000);
      chk_irq("rst_irq", 1'b0);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         irq_in = tbl[i].irqv;
         if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
         else              rd(tbl[i].name, tbl[i].addr, tbl[i].exp);
      end
      irq_in = '0;

      // ---------------- edge pulse, irq latency, W1C ----------------
      do_reset();
      wr(A_MASK, 16'h0001);
      wr(A_MODE, 16'h0001);
      irq_in = 8'h01;
      tick();
      irq_in = 8'h00;
      chk_irq("edge_irq_e0", 1'b0);
      tick();
      chk_irq("edge_irq_e1", 1'b0);
      tick();
      chk_irq("edge_irq_e2", 1'b1);
      rd("edge_pend", A_PEND, 16'h0001);
      wr(A_PEND, 16'h0001);
      chk_irq("edge_irq_w1c_lat", 1'b1);
      tick();
      chk_irq("edge_irq_cleared", 1'b0);

      // ---------------- level hold, W1C ineffective ----------------
      do_reset();
      wr(A_MASK, 16'h0004);
      irq_in = 8'h04;
      tick();
      tick();
      chk_irq("lvl_irq_on", 1'b1);
      wr(A_PEND, 16'h0004);
      rd("lvl_pend_held", A_PEND, 16'h0004);
      irq_in = 8'h00;
      tick();
      tick();
      chk_irq("lvl_irq_off", 1'b0);
      rd("lvl_pend_gone", A_PEND, 16'h0000);

      // ---------------- vector priority ----------------
      do_reset();
      wr(A_MASK, 16'h00FF);
      wr(A_SOFT, 16'h0048);
      rd("vec_3", A_VEC, 16'h8003);
      wr(A_PEND, 16'h0008);
      rd("vec_6", A_VEC, 16'h8006);
      wr(A_PEND, 16'h0040);
      rd("vec_none", A_VEC, 16'h0000);
      chk_irq("vec_irq_off", 1'b0);

      // ---------------- edge set beats coincident W1C ----------------
      do_reset();
      wr(A_MODE, 16'h0002);
      wr(A_SOFT, 16'h0002);
      rd("race_pre", A_PEND, 16'h0002);
      irq_in = 8'h02;
      tick();
      wr(A_PEND, 16'h0002);
      rd("race_edge_wins", A_PEND, 16'h0002);
      wr(A_PEND, 16'h0002);
      rd("race_w1c_alone", A_PEND, 16'h0000);
      irq_in = 8'h00;

      // ---------------- soft set with mask gating ----------------
      do_reset();
      wr(A_MASK, 16'h0000);
      wr(A_SOFT, 16'h0010);
      rd("soft_pend", A_PEND, 16'h0010);
      chk_irq("soft_irq_masked", 1'b0);
      wr(A_MASK, 16'h0010);
      chk_irq("soft_irq_mask_lat", 1'b0);
      tick();
      chk_irq("soft_irq_on", 1'b1);
      rd("soft_vec", A_VEC, 16'h8004);

      // ---------------- mode change keeps pending ----------------
      wr(A_MODE, 16'h0010);
      rd("mode_keep_pend", A_PEND, 16'h0010);

      // ---------------- reset mid-activity ----------------
      wr(A_MASK, 16'h00FF);
      wr(A_SOFT, 16'h00FF);
      tick();
      chk_irq("pre_rst_irq", 1'b1);
      rd("pre_rst_pend", A_PEND, 16'h00FF);
      address    = A_PEND;
      chipselect = 1'b1;
      reset      = 1'b1;
      tick();
      check("post_rst_readdata", readdata, 16'h0000);
      chk_irq("post_rst_irq", 1'b0);
      reset      = 1'b0;
      chipselect = 1'b0;
      rd("post_rst_pend", A_PEND, 16'h0000);
      rd("post_rst_mask", A_MASK, RST_MASK);
      chk_irq("post_rst_irq2", 1'b0);

      // ---------------- input held across reset is not an edge ----------------
      reset      = 1'b1;
      irq_in     = 8'h01;
      address    = A_MODE;
      writedata  = 16'h0001;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      check("rst_write_ignored", readdata, 16'h0000);
      tick();
      reset = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      tick();
      tick();
      rd("held_mode", A_MODE, 16'h0001);
      rd("held_no_latch", A_PEND, 16'h0000);
      irq_in = 8'h00;
      tick();
      tick();
      irq_in = 8'h01;
      tick();
      tick();
      rd("rerise_latch", A_PEND, 16'h0001);
      irq_in = 8'h00;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
